// File: rtl/sync_buffer_fifo.sv
// sync_buffer_fifo: parametrised first-word-fall-through single-clock FIFO.
// Define SYNC_BUFFER_DROP_CNT_EN to build the saturating drop counter.
module sync_buffer_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_1_en,
  input  logic [WIDTH-1:0]           data_1,
  input  logic                       data_2_ready,
  output logic                       buffer_empty,
  output logic                       buffer_full,
  output logic                       buffer_almost_full,
  output logic                       data_2_valid,
  output logic [WIDTH-1:0]           data_2,
  output logic [$clog2(DEPTH):0]     buffer_count,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign buffer_empty       = (cnt_q == '0);
  assign buffer_full        = (cnt_q == CW'(DEPTH));
  assign buffer_almost_full = (cnt_q >= CW'(AF_LEVEL));
  assign buffer_count       = cnt_q;
  assign data_2_valid       = !buffer_empty;
  assign data_2 = buffer_empty ? '0 : mem_q[rd_ptr_q];

  assign push = data_1_en && !buffer_full;
  assign pop  = data_2_valid && data_2_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Contents need no reset: they are masked until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_1;
  end

`ifdef SYNC_BUFFER_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic       drop;

  assign drop = data_1_en && buffer_full;

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/sync_buffer_fifo.md
# sync_buffer_fifo

Parametrised single-clock FIFO buffer between a 16-bit value producer (Fibonacci or Timer module) and the consumer stage. It generalises the team's fixed 8×16 buffer: configurable width and depth, a ready/valid output handshake, an almost-full backpressure flag the producer uses to stop generating values, and an occupancy count. Writes arriving while full are dropped, never overwritten.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, 6, buffer_almost_full asserts when occupancy ≥ AF_LEVEL (1..DEPTH)

- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous and active-low (0 = reset)
- data_1_en  in  1  write request; data_1 valid this cycle
- data_1  in  WIDTH  value from the producer
- data_2_ready  in  1  consumer accepts data_2 this cycle
- buffer_empty  out  1  occupancy == 0
- buffer_full  out  1  occupancy == DEPTH
- buffer_almost_full  out  1  occupancy ≥ AF_LEVEL; producer backpressure
- data_2_valid  out  1  data_2 holds the oldest stored word
- data_2  out  WIDTH  oldest stored word (first-word-fall-through)
- buffer_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_cnt  out  8  count of rejected writes (see Configuration)

## Operation
- Storage: DEPTH×WIDTH register array, write pointer, read pointer, occupancy counter; all registered.
- Push: data_1_en && !buffer_full. Word stored at wr_ptr, wr_ptr advances.
- Drop: data_1_en && buffer_full. Storage, pointers and count unchanged; drop event raised.
- Pop: data_2_valid && data_2_ready. rd_ptr advances. data_2_ready while empty is ignored.
- Push and pop in the same cycle: both take effect; occupancy unchanged.
- Push while empty with data_2_ready high: push only (no pop); occupancy becomes 1.
- Pointers wrap from DEPTH-1 to 0 (modulo DEPTH).
- data_2_valid = !buffer_empty. data_2 = mem[rd_ptr] when valid; drives 0 when empty.
- Flags and buffer_count decode from the registered occupancy counter; no combinational path from inputs to any output.
- Reset (rst = 0, any time, including mid-transfer): pointers and occupancy to 0; contents are don't-care and never exposed.
- Reset values: buffer_empty=1, buffer_full=0, buffer_almost_full=0 (or 1 if AF_LEVEL would be met by 0, which is illegal), data_2_valid=0, data_2=0, buffer_count=0, drop_cnt=0.

## Timing
- Write-to-read latency: 1 cycle. A push sampled at edge k makes data_2_valid=1 and data_2=word in the cycle after edge k.
- Pop sampled at edge k: the next word (or empty) is presented after edge k.
- All flags update on the same edge as the push/pop causing them.
- The producer must stop within 1 cycle of buffer_almost_full; the DEPTH−AF_LEVEL slack absorbs in-flight writes.
- Asynchronous reset assert takes effect immediately; deassert is expected synchronous to clk (synchronised upstream).

## Configuration
- Macro SYNC_BUFFER_DROP_CNT_EN.
- Defined: drop_cnt is an 8-bit counter incremented on each drop event, saturating at 255, cleared only by reset.
- Not defined: counter logic omitted; drop_cnt tied to 0. All other behaviour identical.

## Test plan
- Reset, then push 0x0001..0x0008 on consecutive cycles with data_2_ready=0 -> buffer_count 8, buffer_full=1, buffer_almost_full=1 from the 6th push, data_2=0x0001.
- Full buffer, data_1_en=1 with data_1=0xDEAD for 3 cycles -> contents unchanged; drop_cnt=3 with macro, 0 without.
- Drain the full buffer with data_2_ready=1 -> data_2 sequence 0x0001..0x0008 on 8 consecutive cycles; then buffer_empty=1, data_2=0.
- Occupancy 4, simultaneous push and pop for 20 cycles with incrementing data -> buffer_count stays 4; FIFO order preserved across pointer wrap.
- Empty buffer, push 0x00AA with data_2_ready=1 -> next cycle data_2_valid=1, data_2=0x00AA, buffer_count=1.
- Occupancy 5, assert rst=0 mid-push for 1 cycle -> all outputs at reset values immediately; subsequent push of 0x1234 is read first.
